// File: rtl/prt_frame_tx.sv
// Streams one stored frame from a PRT slot to the MAC, one byte per PRT read.
// Unanswered reads are retried until the stall limit, then the frame is terminated with an error byte.
module prt_frame_tx #(
  parameter int unsigned Index_Size = 1,
  parameter int unsigned Table_Size = 2,
  parameter int unsigned FrameSize  = 1518,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [Index_Size-1:0] cmd_slot,
  output logic                  cmd_ready,
  output logic                  prt_start,
  output logic [Index_Size-1:0] prt_slot,
  output logic                  prt_req,
  input  logic                  prt_rsp_valid,
  input  logic [7:0]            prt_rsp_data,
  input  logic                  prt_rsp_last,
  output logic                  prt_inval,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  output logic                  tx_err,
  input  logic                  tx_ready,
  output logic                  done,
  output logic [Index_Size-1:0] done_slot,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, START, REQ, WAIT, SEND, ABORT} state_t;

  state_t                state, state_next;
  logic [Index_Size-1:0] slot;
  logic [7:0]            data_q;
  logic                  last_q;
  logic [10:0]           byte_cnt;
  logic [15:0]           stall_cnt;
  logic                  aborted;
  logic [10:0]           byte_inc;
  logic [15:0]           stall_inc;
  logic                  accept, capture, miss, sent;

  assign byte_inc  = byte_cnt + 11'd1;
  assign stall_inc = stall_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      slot      <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      aborted   <= 1'b0;
    end else begin
      state   <= state_next;
      // Marks every ABORT cycle after the first, so prt_inval fires exactly once.
      aborted <= (state == ABORT);
      if (accept) begin
        assert (32'(cmd_slot) < Table_Size);
        slot      <= cmd_slot;
        byte_cnt  <= '0;
        stall_cnt <= '0;
      end
      if (capture) begin
        data_q    <= prt_rsp_data;
        last_q    <= prt_rsp_last;
        stall_cnt <= '0;
      end
      if (miss) stall_cnt <= stall_inc;
      if (sent) byte_cnt <= byte_inc;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    prt_start  = 1'b0;
    prt_slot   = '0;
    prt_req    = 1'b0;
    prt_inval  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    tx_last    = 1'b0;
    tx_err     = 1'b0;
    done       = 1'b0;
    done_slot  = '0;
    busy       = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    miss       = 1'b0;
    sent       = 1'b0;
    if (reset) begin
      cmd_ready = 1'b1;
    end else begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            accept     = 1'b1;
            state_next = START;
          end
        end
        START: begin
          prt_start  = 1'b1;
          prt_slot   = slot;
          state_next = REQ;
        end
        REQ: begin
          prt_req    = 1'b1;
          state_next = WAIT;
        end
        WAIT: begin
          if (prt_rsp_valid) begin
            capture    = 1'b1;
            state_next = SEND;
          end else begin
            miss       = 1'b1;
            state_next = (32'(stall_inc) >= TIMEOUT) ? ABORT : REQ;
          end
        end
        SEND: begin
          tx_valid = 1'b1;
          tx_data  = data_q;
          tx_last  = last_q;
          if (tx_ready) begin
            sent = 1'b1;
            if (last_q) begin
              done       = 1'b1;
              done_slot  = slot;
              state_next = IDLE;
            end else if (32'(byte_inc) == FrameSize) begin
              state_next = ABORT;
            end else begin
              state_next = REQ;
            end
          end
        end
        ABORT: begin
          if (!aborted) begin
            prt_inval = 1'b1;
            prt_slot  = slot;
          end else begin
            tx_valid = 1'b1;
            tx_last  = 1'b1;
            tx_err   = 1'b1;
            if (tx_ready) begin
              done       = 1'b1;
              done_slot  = slot;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prt_frame_tx.sv
// Directed bench for prt_frame_tx with a small behavioural PRT responder.
module tb_prt_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [0:0] cmd_slot = '0;
  logic       cmd_ready;
  logic       prt_start;
  logic [0:0] prt_slot;
  logic       prt_req;
  logic       prt_rsp_valid = 1'b0;
  logic [7:0] prt_rsp_data = '0;
  logic       prt_rsp_last = 1'b0;
  logic       prt_inval;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_err;
  logic       tx_ready = 1'b1;
  logic       done;
  logic [0:0] done_slot;
  logic       busy;

  prt_frame_tx #(
    .Index_Size(1),
    .Table_Size(2),
    .FrameSize (8),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_slot     (cmd_slot),
    .cmd_ready    (cmd_ready),
    .prt_start    (prt_start),
    .prt_slot     (prt_slot),
    .prt_req      (prt_req),
    .prt_rsp_valid(prt_rsp_valid),
    .prt_rsp_data (prt_rsp_data),
    .prt_rsp_last (prt_rsp_last),
    .prt_inval    (prt_inval),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_err       (tx_err),
    .tx_ready     (tx_ready),
    .done         (done),
    .done_slot    (done_slot),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // PRT model contents and response control
  logic [7:0] frame [16];
  int  frame_len = 0;
  bit  frame_has_last = 1'b0;
  int  rd_ptr = 0;
  int  withhold = 0;
  bit  req_seen = 1'b0;

  // Event log
  int cyc = 0, hs_cyc = 0;
  int n_start, n_req, n_inval, n_done, n_txv;
  int start_slot, inval_slot, inval_cyc, done_slot_q;
  bit inval_txv;
  logic [7:0] got_d [$];
  bit got_l [$];
  bit got_e [$];
  int got_c [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    n_start = 0; n_req = 0; n_inval = 0; n_done = 0; n_txv = 0;
    start_slot = -1; inval_slot = -1; inval_cyc = -1; done_slot_q = -1;
    inval_txv = 1'b0;
    got_d.delete(); got_l.delete(); got_e.delete(); got_c.delete();
  endtask

  // Sample one cycle before its edge, then apply the PRT response for the next cycle.
  task automatic tick();
    #1;
    if (prt_start) begin n_start++; start_slot = int'(prt_slot); rd_ptr = 0; end
    if (prt_req) n_req++;
    if (prt_inval) begin
      n_inval++; inval_slot = int'(prt_slot); inval_cyc = cyc; inval_txv = tx_valid;
    end
    if (tx_valid) n_txv++;
    if (tx_valid && tx_ready) begin
      got_d.push_back(tx_data); got_l.push_back(tx_last);
      got_e.push_back(tx_err);  got_c.push_back(cyc);
    end
    if (done) begin n_done++; done_slot_q = int'(done_slot); end
    if (cmd_valid && cmd_ready) hs_cyc = cyc;
    req_seen = prt_req;
    cyc++;
    @(posedge clk);
    #1;
    if (req_seen && withhold == 0) begin
      prt_rsp_valid = 1'b1;
      prt_rsp_data  = frame[rd_ptr];
      prt_rsp_last  = frame_has_last && (rd_ptr == frame_len - 1);
      rd_ptr++;
    end else begin
      prt_rsp_valid = 1'b0;
      prt_rsp_data  = 8'h00;
      prt_rsp_last  = 1'b0;
    end
    if (withhold > 0) withhold--;
  endtask

  task automatic send_cmd(input logic [0:0] s);
    cmd_slot  = s;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = n_done;
    int i  = 0;
    while (n_done == d0 && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_done"}, n_done - d0, 1);
  endtask

  // Compares the logged egress bytes with the loaded frame.
  task automatic check_frame(input string tag, input int n);
    check({tag, "_count"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check({tag, "_data"}, got_d[i], frame[i]);
      check({tag, "_last"}, got_l[i], (frame_has_last && i == n - 1) ? 1 : 0);
      check({tag, "_err"},  got_e[i], 0);
    end
  endtask

  initial begin
    int n0, t0, i;
    bit stable;
    clear_log();
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_prt_req", prt_req, 0);
    reset = 1'b0;
    tick();

    // Basic 4-byte frame from slot 1
    frame[0] = 8'hA1; frame[1] = 8'hB2; frame[2] = 8'hC3; frame[3] = 8'hD4;
    frame_len = 4; frame_has_last = 1'b1;
    clear_log();
    send_cmd(1'b1);
    check("basic_start_pulse", prt_start, 1);
    check("basic_start_slot", prt_slot, 1);
    check("basic_busy", busy, 1);
    tick(); tick(); tick();
    check("basic_first_valid", tx_valid, 1);
    check("basic_first_data", tx_data, 8'hA1);
    wait_done("basic", 100);
    check("basic_n_start", n_start, 1);
    check("basic_start_slot_log", start_slot, 1);
    check("basic_n_req", n_req, 4);
    check_frame("basic", 4);
    check("basic_latency", got_c[0] - hs_cyc, 4);
    check("basic_rate", got_c[3] - got_c[0], 9);
    check("basic_done_slot", done_slot_q, 1);
    check("basic_no_inval", n_inval, 0);
    tick();
    check("basic_idle", busy, 0);

    // Egress backpressure while B2 is presented
    clear_log();
    send_cmd(1'b1);
    i = 0;
    while (!(tx_valid === 1'b1 && tx_data === 8'hB2) && i < 30) begin tick(); i++; end
    check("bp_reach_b2", tx_data, 8'hB2);
    tx_ready = 1'b0;
    n0 = n_req;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (tx_valid !== 1'b1 || tx_data !== 8'hB2 || tx_last !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_no_req", n_req - n0, 0);
    tx_ready = 1'b1;
    wait_done("bp", 100);
    check_frame("bp", 4);

    // PRT withholds responses for 10 cycles after the first byte
    clear_log();
    send_cmd(1'b1);
    i = 0;
    while (got_d.size() < 1 && i < 30) begin tick(); i++; end
    withhold = 10;
    n0 = n_req;
    t0 = n_txv;
    for (int k = 0; k < 11; k++) tick();
    check("stall_retries", n_req - n0, 6);
    check("stall_no_valid", n_txv - t0, 0);
    wait_done("stall", 100);
    check_frame("stall", 4);
    check("stall_no_inval", n_inval, 0);

    // Single-byte frame
    frame[0] = 8'h5A; frame_len = 1; frame_has_last = 1'b1;
    clear_log();
    send_cmd(1'b0);
    wait_done("one", 50);
    check_frame("one", 1);
    check("one_n_req", n_req, 1);
    check("one_done_slot", done_slot_q, 0);
    check("one_no_inval", n_inval, 0);

    // Timeout: no responses at all
    clear_log();
    withhold = 1000;
    send_cmd(1'b0);
    wait_done("tmo", 100);
    withhold = 0;
    check("tmo_n_req", n_req, 16);
    check("tmo_n_inval", n_inval, 1);
    check("tmo_inval_slot", inval_slot, 0);
    check("tmo_inval_no_valid", inval_txv, 0);
    check("tmo_count", got_d.size(), 1);
    check("tmo_term_data", got_d[0], 8'h00);
    check("tmo_term_last", got_l[0], 1);
    check("tmo_term_err", got_e[0], 1);
    check("tmo_term_after_inval", got_c[0] - inval_cyc, 1);
    check("tmo_done_slot", done_slot_q, 0);

    // Frame longer than FrameSize
    for (int k = 0; k < 8; k++) frame[k] = 8'(8'h11 * (k + 1));
    frame_len = 8; frame_has_last = 1'b0;
    clear_log();
    send_cmd(1'b1);
    wait_done("max", 100);
    check("max_count", got_d.size(), 9);
    for (int k = 0; k < 8; k++) begin
      check("max_data", got_d[k], frame[k]);
      check("max_last", got_l[k], 0);
      check("max_err", got_e[k], 0);
    end
    check("max_term_data", got_d[8], 8'h00);
    check("max_term_last", got_l[8], 1);
    check("max_term_err", got_e[8], 1);
    check("max_n_inval", n_inval, 1);
    check("max_inval_slot", inval_slot, 1);
    check("max_done_slot", done_slot_q, 1);

    // Reset while in SEND
    frame[0] = 8'hA1; frame[1] = 8'hB2; frame[2] = 8'hC3; frame[3] = 8'hD4;
    frame_len = 4; frame_has_last = 1'b1;
    clear_log();
    send_cmd(1'b1);
    i = 0;
    while (tx_valid !== 1'b1 && i < 20) begin tick(); i++; end
    check("mrst_in_send", tx_valid, 1);
    tx_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("mrst_tx_valid", tx_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cmd_ready", cmd_ready, 1);
    check("mrst_prt_inval", prt_inval, 0);
    check("mrst_n_inval", n_inval, 0);
    reset = 1'b0;
    tx_ready = 1'b1;
    tick();
    check("mrst_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prt_frame_tx.md
PRT_FRAME_TX -- requirements
Module: prt_frame_tx

Interface
REQ-001 SHALL have parameter Index_Size, default 1, PRT slot index width.
REQ-002 SHALL have parameter Table_Size, default 2, PRT slot count; cmd_slot >= Table_Size is illegal stimulus.
REQ-003 SHALL have parameter FrameSize, default 1518, maximum bytes per frame.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum cycles since the last received byte.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset; one clock, synchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  transmit request for one stored frame.
REQ-008 SHALL have port cmd_slot  input  Index_Size  PRT slot to transmit.
REQ-009 SHALL have port cmd_ready  output  1  request accepted when cmd_valid and cmd_ready are high together.
REQ-010 SHALL have port prt_start  output  1  one-cycle start-reading pulse to the PRT.
REQ-011 SHALL have port prt_slot  output  Index_Size  slot for prt_start and prt_inval.
REQ-012 SHALL have port prt_req  output  1  one-cycle read-byte request.
REQ-013 SHALL have port prt_rsp_valid  input  1  PRT byte response, one cycle after prt_req, or absent if the byte is not yet received.
REQ-014 SHALL have port prt_rsp_data  input  8  response byte.
REQ-015 SHALL have port prt_rsp_last  input  1  response byte is the final frame byte.
REQ-016 SHALL have port prt_inval  output  1  one-cycle invalidate pulse for prt_slot.
REQ-017 SHALL have ports tx_valid/tx_data/tx_last/tx_err  output  1/8/1/1  egress byte stream toward the MAC.
REQ-018 SHALL have port tx_ready  input  1  egress accepts the byte when tx_valid and tx_ready are high together.
REQ-019 SHALL have ports done/done_slot/busy  output  1/Index_Size/1  completion pulse, completed slot, and busy status (state != IDLE).

Function
REQ-020 SHALL implement states IDLE, START, REQ, WAIT, SEND, ABORT.
REQ-021 SHALL, in IDLE, drive cmd_ready=1 and, on handshake, latch cmd_slot, clear byte and stall counters, and go to START.
REQ-022 SHALL, in START, pulse prt_start with prt_slot=latched slot for one cycle, then go to REQ.
REQ-023 SHALL, in REQ, pulse prt_req for one cycle, then go to WAIT.
REQ-024 SHALL, in WAIT (one cycle), capture data/last and go to SEND if prt_rsp_valid=1; otherwise go to REQ (retry) and increment the 16-bit stall counter.
REQ-025 SHALL ignore prt_rsp_valid in every state except WAIT.
REQ-026 SHALL clear the stall counter on each captured byte, and go to ABORT from WAIT when the stall counter reaches TIMEOUT.
REQ-027 SHALL, in SEND, drive tx_valid=1, tx_data, and tx_last=captured last, holding all three stable until tx_ready; each byte is requested from the PRT exactly once.
REQ-028 SHALL, on SEND handshake, increment an 11-bit byte counter, then: if last, pulse done with done_slot and go to IDLE; else if count==FrameSize, go to ABORT; else go to REQ.
REQ-029 SHALL never assert prt_inval on normal completion, because the PRT self-invalidates on its last byte.
REQ-030 SHALL, on the first ABORT cycle only, pulse prt_inval with prt_slot; then hold tx_valid=1, tx_last=1, tx_err=1, tx_data=0x00 until tx_ready, then pulse done and go to IDLE.
REQ-031 SHALL, with immediate responses and tx_ready=1, raise the first tx_valid 4 cycles after cmd handshake, and sustain one byte per 3 cycles thereafter.
REQ-032 SHALL treat a first response with prt_rsp_last=1 as a valid 1-byte frame.
REQ-033 SHALL keep tx_err=0 except in ABORT.

Reset
REQ-034 SHALL, while reset=1, enter IDLE and drive every output to 0 except cmd_ready=1, clear all counters, and issue no prt_inval even mid-frame; slot cleanup belongs to the PRT owner.

Verification
REQ-035 SHALL cover: slot 1 holds A1 B2 C3 D4 (last on D4), tx_ready=1 -> one prt_start with prt_slot=1, four prt_req, tx bytes A1..D4, tx_last only on D4, done with done_slot=1, no prt_inval.
REQ-036 SHALL cover: tx_ready low 5 cycles while B2 is presented -> tx_data=B2 held stable, no prt_req during the stall.
REQ-037 SHALL cover: PRT withholds responses 10 cycles mid-frame -> prt_req retried every 2 cycles, tx_valid=0, frame resumes intact.
REQ-038 SHALL cover: TIMEOUT=16 with no responses -> prt_inval one cycle, then terminator (valid, last, err, data 0x00), then done.
REQ-039 SHALL cover: FrameSize=8 with 8 bytes and no last -> 8 data bytes, then ABORT terminator with prt_inval.
REQ-040 SHALL cover: reset asserted in SEND -> next cycle tx_valid=0, busy=0, cmd_ready=1, prt_inval=0.
